comp_fiber_framer_tx: RTL and testbench

COMP_FIBER_FRAMER_TX -- requirements
Module: comp_fiber_framer_tx

---
 rtl/comp_fiber_framer_tx.sv | 119 +++++++++++
 tb/tb_comp_fiber_framer_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/comp_fiber_framer_tx.sv
// Fiber link transmit framer: packs 48-bit payload words into 4-word frames
// (comma + frame count, then three 16-bit payload slices) for an 8b10b GTX lane.
module comp_fiber_framer_tx #(
  parameter logic [47:0] IDLE_PAYLOAD = 48'h000000000000,
  parameter int          CNT_W        = 16
) (
  input  logic             cmp_tx_clk160,
  input  logic             rst_n,
  input  logic             en,
  input  logic [47:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ltncy_req,
  output logic [15:0]      tx_data,
  output logic [1:0]       tx_charisk,
  output logic             frame_start,
  output logic             ltncy_pend,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [1:0]       phase_dbg
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready is registered and means "holding register empty".

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t           phase;
  logic [47:0]      payload;
  logic [47:0]      hold_data;
  logic             hold_full;

  logic             boundary;
  logic             xfer;
  logic             take_hold;
  logic             take_bypass;
  logic             starve;
  logic             load_hold;
  logic             hold_full_next;
  logic             mark;
  logic [CNT_W-1:0] fcnt_next;
  logic [47:0]      next_payload;

  assign phase_dbg = phase;

  always_comb begin
    boundary    = (phase == PH3);
    xfer        = in_valid && in_ready;
    take_hold   = boundary && en && hold_full;
    take_bypass = boundary && en && !hold_full && xfer;
    starve      = boundary && en && !hold_full && !xfer;
    // A transfer that is not consumed directly by a starting frame is never
    // dropped; with en low at the boundary it still lands in the holding reg.
    load_hold   = xfer && !(boundary && en);
    hold_full_next = hold_full;
    if (load_hold)      hold_full_next = 1'b1;
    else if (take_hold) hold_full_next = 1'b0;
    mark      = ltncy_pend || ltncy_req;
    fcnt_next = frame_cnt + 1'b1;
    next_payload = IDLE_PAYLOAD;
    if (take_hold)        next_payload = hold_data;
    else if (take_bypass) next_payload = in_data;
  end

  always_ff @(posedge cmp_tx_clk160 or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= PH0;
      tx_data      <= 16'h00BC;
      tx_charisk   <= 2'b01;
      frame_start  <= 1'b1;
      payload      <= IDLE_PAYLOAD;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      in_ready     <= 1'b0;
      ltncy_pend   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      hold_full <= hold_full_next;
      in_ready  <= !hold_full_next;
      if (load_hold) hold_data <= in_data;
      underrun <= starve;
      if (starve && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
      ltncy_pend <= boundary ? 1'b0 : (ltncy_pend || ltncy_req);
      case (phase)
        PH0: begin
          phase       <= PH1;
          tx_data     <= payload[15:0];
          tx_charisk  <= 2'b00;
          frame_start <= 1'b0;
        end
        PH1: begin
          phase       <= PH2;
          tx_data     <= payload[31:16];
          tx_charisk  <= 2'b00;
          frame_start <= 1'b0;
        end
        PH2: begin
          phase       <= PH3;
          tx_data     <= payload[47:32];
          tx_charisk  <= 2'b00;
          frame_start <= 1'b0;
        end
        default: begin
          // Word 0 carries the count of the frame that starts on this edge.
          phase       <= PH0;
          payload     <= next_payload;
          frame_cnt   <= fcnt_next;
          tx_data     <= {8'(fcnt_next), (mark ? 8'hFC : 8'hBC)};
          tx_charisk  <= 2'b01;
          frame_start <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comp_fiber_framer_tx.sv
// Bench for comp_fiber_framer_tx: per-cycle vector table plus hand-written
// sequences for counter saturation/wrap and mid-frame reset.
module tb_comp_fiber_framer_tx;

  localparam int CNT_W = 4;
  localparam logic [47:0] DATA = 48'hAAAA_5555_1234;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [47:0]      in_data = DATA;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ltncy_req = 1'b0;
  logic [15:0]      tx_data;
  logic [1:0]       tx_charisk;
  logic             frame_start;
  logic             ltncy_pend;
  logic             underrun;
  logic [CNT_W-1:0] underrun_cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       phase_dbg;

  int n_cmp = 0;
  int n_fail = 0;

  comp_fiber_framer_tx #(.IDLE_PAYLOAD(48'h0), .CNT_W(CNT_W)) dut (
    .cmp_tx_clk160(clk), .rst_n(rst_n), .en(en), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ltncy_req(ltncy_req),
    .tx_data(tx_data), .tx_charisk(tx_charisk), .frame_start(frame_start),
    .ltncy_pend(ltncy_pend), .underrun(underrun), .underrun_cnt(underrun_cnt),
    .frame_cnt(frame_cnt), .phase_dbg(phase_dbg)
  );

  always #3 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en, valid, lreq;
    logic [15:0] data;
    logic        rdy, und;
    logic [3:0]  ucnt, fcnt;
    logic        pend;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic e, v, l, input logic [15:0] d,
                              input logic r, u, input logic [3:0] uc, fc,
                              input logic p);
    vec_t t;
    t.en = e; t.valid = v; t.lreq = l; t.data = d; t.rdy = r; t.und = u;
    t.ucnt = uc; t.fcnt = fc; t.pend = p;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " tx_data"}, tx_data, 16'h00BC);
    chk({tag, " charisk"}, 16'(tx_charisk), 16'h1);
    chk({tag, " frame_start"}, 16'(frame_start), 16'h1);
    chk({tag, " in_ready"}, 16'(in_ready), 16'h0);
    chk({tag, " ltncy_pend"}, 16'(ltncy_pend), 16'h0);
    chk({tag, " underrun"}, 16'(underrun), 16'h0);
    chk({tag, " underrun_cnt"}, 16'(underrun_cnt), 16'h0);
    chk({tag, " frame_cnt"}, 16'(frame_cnt), 16'h0);
  endtask

  initial begin
    // Row n is the expected state just after rising edge n+1 after reset release.
    // Idle underrun frames.
    add(1,0,0,16'h0000,1,0,0,0,0); add(1,0,0,16'h0000,1,0,0,0,0); add(1,0,0,16'h0000,1,0,0,0,0);
    add(1,0,0,16'h01BC,1,1,1,1,0);
    add(1,0,0,16'h0000,1,0,1,1,0); add(1,0,0,16'h0000,1,0,1,1,0); add(1,0,0,16'h0000,1,0,1,1,0);
    add(1,0,0,16'h02BC,1,1,2,2,0);
    // Continuous stream: loads the holding register, sent in the next frame.
    add(1,1,0,16'h0000,0,0,2,2,0); add(1,1,0,16'h0000,0,0,2,2,0); add(1,1,0,16'h0000,0,0,2,2,0);
    add(1,1,0,16'h03BC,1,0,2,3,0);
    add(1,1,0,16'h1234,0,0,2,3,0); add(1,1,0,16'h5555,0,0,2,3,0); add(1,1,0,16'hAAAA,0,0,2,3,0);
    add(1,1,0,16'h04BC,1,0,2,4,0);
    // Latency request in phase 1, then on the boundary edge, then twice.
    add(1,1,0,16'h1234,0,0,2,4,0); add(1,1,1,16'h5555,0,0,2,4,1); add(1,1,0,16'hAAAA,0,0,2,4,1);
    add(1,1,0,16'h05FC,1,0,2,5,0);
    add(1,1,0,16'h1234,0,0,2,5,0); add(1,1,0,16'h5555,0,0,2,5,0); add(1,1,0,16'hAAAA,0,0,2,5,0);
    add(1,1,0,16'h06BC,1,0,2,6,0);
    add(1,1,0,16'h1234,0,0,2,6,0); add(1,1,0,16'h5555,0,0,2,6,0); add(1,1,0,16'hAAAA,0,0,2,6,0);
    add(1,1,1,16'h07FC,1,0,2,7,0);
    add(1,1,0,16'h1234,0,0,2,7,0); add(1,1,1,16'h5555,0,0,2,7,1); add(1,1,1,16'hAAAA,0,0,2,7,1);
    add(1,1,0,16'h08FC,1,0,2,8,0);
    add(1,1,0,16'h1234,0,0,2,8,0); add(1,1,0,16'h5555,0,0,2,8,0); add(1,1,0,16'hAAAA,0,0,2,8,0);
    add(1,1,0,16'h09BC,1,0,2,9,0);
    // Hold one word, then en low across a boundary: idle frame, word kept.
    add(1,1,0,16'h1234,0,0,2,9,0); add(1,0,0,16'h5555,0,0,2,9,0); add(1,0,0,16'hAAAA,0,0,2,9,0);
    add(0,0,0,16'h0ABC,0,0,2,10,0);
    add(0,0,0,16'h0000,0,0,2,10,0); add(0,0,0,16'h0000,0,0,2,10,0); add(0,0,0,16'h0000,0,0,2,10,0);
    add(1,0,0,16'h0BBC,1,0,2,11,0);
    add(1,0,0,16'h1234,1,0,2,11,0); add(1,0,0,16'h5555,1,0,2,11,0); add(1,0,0,16'hAAAA,1,0,2,11,0);
    add(1,0,0,16'h0CBC,1,1,3,12,0);
    // Bypass: valid only on the boundary edge, word 1 appears one clock later.
    add(1,0,0,16'h0000,1,0,3,12,0); add(1,0,0,16'h0000,1,0,3,12,0); add(1,0,0,16'h0000,1,0,3,12,0);
    add(1,1,0,16'h0DBC,1,0,3,13,0);
    add(1,0,0,16'h1234,1,0,3,13,0); add(1,0,0,16'h5555,1,0,3,13,0); add(1,0,0,16'hAAAA,1,0,3,13,0);
    add(1,0,0,16'h0EBC,1,1,4,14,0);
    add(1,0,0,16'h0000,1,0,4,14,0); add(1,0,0,16'h0000,1,0,4,14,0); add(1,0,0,16'h0000,1,0,4,14,0);
    add(1,0,0,16'h0FBC,1,1,5,15,0);
    add(1,0,0,16'h0000,1,0,5,15,0); add(1,0,0,16'h0000,1,0,5,15,0); add(1,0,0,16'h0000,1,0,5,15,0);
    add(1,0,0,16'h00BC,1,1,6,0,0);

    // Reset state, then release away from the clock edge.
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      logic w0;
      en = tbl[i].en; in_valid = tbl[i].valid; ltncy_req = tbl[i].lreq;
      @(posedge clk);
      #1;
      w0 = ((i % 4) == 3);
      chk($sformatf("v%0d tx_data", i), tx_data, tbl[i].data);
      chk($sformatf("v%0d charisk", i), 16'(tx_charisk), w0 ? 16'h1 : 16'h0);
      chk($sformatf("v%0d frame_start", i), 16'(frame_start), 16'(w0));
      chk($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(tbl[i].rdy));
      chk($sformatf("v%0d underrun", i), 16'(underrun), 16'(tbl[i].und));
      chk($sformatf("v%0d underrun_cnt", i), 16'(underrun_cnt), 16'(tbl[i].ucnt));
      chk($sformatf("v%0d frame_cnt", i), 16'(frame_cnt), 16'(tbl[i].fcnt));
      chk($sformatf("v%0d ltncy_pend", i), 16'(ltncy_pend), 16'(tbl[i].pend));
    end

    // Underrun count saturates at 15; frame count keeps wrapping.
    en = 1'b1; in_valid = 1'b0; ltncy_req = 1'b0;
    for (int f = 1; f <= 11; f++) begin
      logic [7:0] fb;
      int uexp;
      repeat (4) @(posedge clk);
      #1;
      fb = 8'(f % 16);
      uexp = (6 + f > 15) ? 15 : 6 + f;
      chk($sformatf("sat%0d tx_data", f), tx_data, {fb, 8'hBC});
      chk($sformatf("sat%0d underrun", f), 16'(underrun), 16'h1);
      chk($sformatf("sat%0d underrun_cnt", f), 16'(underrun_cnt), 16'(uexp));
      chk($sformatf("sat%0d frame_cnt", f), 16'(frame_cnt), 16'(f % 16));
    end

    // Reset in phase 2 with a word held and a latency request pending.
    in_valid = 1'b1; ltncy_req = 1'b1;
    @(posedge clk);
    #1;
    chk("mid held in_ready", 16'(in_ready), 16'h0);
    chk("mid ltncy_pend", 16'(ltncy_pend), 16'h1);
    in_valid = 1'b0; ltncy_req = 1'b0;
    @(posedge clk);
    #1;
    chk("mid phase2 tx_data", tx_data, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset word1", tx_data, 16'h0000);
    chk("post reset in_ready", 16'(in_ready), 16'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("post reset boundary tx_data", tx_data, 16'h01BC);
    chk("post reset held lost underrun", 16'(underrun), 16'h1);
    chk("post reset underrun_cnt", 16'(underrun_cnt), 16'h1);
    chk("post reset frame_cnt", 16'(frame_cnt), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
